// File: rtl/a_fifo_core_if.sv
// Producer/consumer handshake bundle for a_fifo_core.
// The FIFO_COUNT_EN macro adds the occupancy count signal.
interface a_fifo_core_if #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8
);
  localparam int AWIDTH = $clog2(DEPTH);

  logic [DWIDTH-1:0] din;
  logic              wr;
  logic              rd;
  logic              full;
  logic [DWIDTH-1:0] dout;
  logic              empty;
`ifdef FIFO_COUNT_EN
  logic [AWIDTH:0]   count;
`endif

  modport master (
    output din, wr, rd,
`ifdef FIFO_COUNT_EN
    input  count,
`endif
    input  full, dout, empty
  );

  modport slave (
    input  din, wr, rd,
`ifdef FIFO_COUNT_EN
    output count,
`endif
    output full, dout, empty
  );
endinterface

// File: rtl/a_fifo_core.sv
// Single-clock byte FIFO: register array, wrap-bit binary pointers, registered flags/data.
// Defining FIFO_COUNT_EN adds a registered occupancy count on the interface.
module a_fifo_core #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic             clka,
  input  logic             rstb_clka,
  a_fifo_core_if.slave     bus
);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH:0]   wptr, rptr, wptr_nxt, rptr_nxt;
  logic [DWIDTH-1:0] dout_q;
  logic              full_q, empty_q;
  logic              wr_acc, rd_acc;

  // Accept decisions use the flags as registered before this edge.
  assign wr_acc   = bus.wr & ~full_q;
  assign rd_acc   = bus.rd & ~empty_q;
  assign wptr_nxt = wr_acc ? wptr + 1'b1 : wptr;
  assign rptr_nxt = rd_acc ? rptr + 1'b1 : rptr;

  always_ff @(posedge clka) begin
    if (wr_acc) mem[wptr[AWIDTH-1:0]] <= bus.din;
  end

  always_ff @(posedge clka or negedge rstb_clka) begin
    if (!rstb_clka) begin
      wptr    <= '0;
      rptr    <= '0;
      dout_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      wptr    <= wptr_nxt;
      rptr    <= rptr_nxt;
      if (rd_acc) dout_q <= mem[rptr[AWIDTH-1:0]];
      empty_q <= (wptr_nxt == rptr_nxt);
      full_q  <= (wptr_nxt[AWIDTH] != rptr_nxt[AWIDTH]) &&
                 (wptr_nxt[AWIDTH-1:0] == rptr_nxt[AWIDTH-1:0]);
    end
  end

`ifdef FIFO_COUNT_EN
  logic [AWIDTH:0] count_q;

  always_ff @(posedge clka or negedge rstb_clka) begin
    if (!rstb_clka) count_q <= '0;
    else            count_q <= wptr_nxt - rptr_nxt;
  end

  assign bus.count = count_q;
`endif

  assign bus.dout  = dout_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;

endmodule

// File: tb/tb_a_fifo_core.sv
// Directed bench for a_fifo_core; count checks are active when FIFO_COUNT_EN is defined.
module tb_a_fifo_core;
  logic clka;
  logic rstb_clka;
  int   n_run;
  int   n_fail;

  a_fifo_core_if #(.DWIDTH(8), .DEPTH(8)) bus ();

  a_fifo_core #(.DWIDTH(8), .DEPTH(8)) u_dut (
    .clka      (clka),
    .rstb_clka (rstb_clka),
    .bus       (bus.slave)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given request levels; inputs drop again 1ns after the edge.
  task automatic step(input logic w, input logic r, input logic [7:0] d);
    bus.wr  = w;
    bus.rd  = r;
    bus.din = d;
    @(posedge clka);
    #1;
    bus.wr  = 1'b0;
    bus.rd  = 1'b0;
  endtask

  task automatic chk_count(input string tag, input int exp);
`ifdef FIFO_COUNT_EN
    chk(tag, 32'(bus.count), exp);
`else
    if (exp < 0) $display("count %s unused", tag);
`endif
  endtask

  initial begin
    n_run     = 0;
    n_fail    = 0;
    bus.wr    = 1'b0;
    bus.rd    = 1'b0;
    bus.din   = 8'h00;
    rstb_clka = 1'b0;
    repeat (4) @(posedge clka);
    #1;
    rstb_clka = 1'b1;
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full), 0);
    chk("rst_dout",  32'(bus.dout), 8'h00);
    chk_count("rst_count", 0);

    // Single item
    step(1'b1, 1'b0, 8'hCA);
    chk("single_empty_after_wr", 32'(bus.empty), 0);
    step(1'b0, 1'b1, 8'h00);
    chk("single_dout", 32'(bus.dout), 8'hCA);
    chk("single_empty_after_rd", 32'(bus.empty), 1);

    // Overflow: 10 writes, last two dropped
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 8'(8'hCB + i));
      chk($sformatf("ovf_full_%0d", i), 32'(bus.full), (i >= 7) ? 1 : 0);
      chk($sformatf("ovf_empty_%0d", i), 32'(bus.empty), 0);
      chk_count($sformatf("ovf_count_%0d", i), (i >= 7) ? 8 : i + 1);
    end

    // Drain: 12 reads, last four rejected
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("drain_dout_%0d", i), 32'(bus.dout), (i >= 7) ? 8'hD2 : 8'hCB + i);
      chk($sformatf("drain_empty_%0d", i), 32'(bus.empty), (i >= 7) ? 1 : 0);
      chk($sformatf("drain_full_%0d", i), 32'(bus.full), 0);
    end

    // Underflow, then a write that lands after pointer wrap
    step(1'b0, 1'b1, 8'h00);
    chk("unf_dout",  32'(bus.dout), 8'hD2);
    chk("unf_empty", 32'(bus.empty), 1);
    chk_count("unf_count", 0);
    step(1'b1, 1'b0, 8'hFA);
    chk("wrap_empty_wr", 32'(bus.empty), 0);
    step(1'b0, 1'b1, 8'h00);
    chk("wrap_dout",  32'(bus.dout), 8'hFA);
    chk("wrap_empty", 32'(bus.empty), 1);

    // Simultaneous access at occupancy 4
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 8'(8'h14 + i));
      chk($sformatf("sim_dout_%0d", i), 32'(bus.dout), 8'h10 + i);
      chk($sformatf("sim_empty_%0d", i), 32'(bus.empty), 0);
      chk($sformatf("sim_full_%0d", i), 32'(bus.full), 0);
      chk_count($sformatf("sim_count_%0d", i), 4);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("sim_tail_dout_%0d", i), 32'(bus.dout), 8'h16 + i);
    end
    chk("sim_tail_empty", 32'(bus.empty), 1);

    // Simultaneous access while full: read accepted, write dropped
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
    chk("fullrw_pre_full", 32'(bus.full), 1);
    step(1'b1, 1'b1, 8'hEE);
    chk("fullrw_dout", 32'(bus.dout), 8'h20);
    chk("fullrw_full", 32'(bus.full), 0);
    chk_count("fullrw_count", 7);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, 8'h00);
      chk($sformatf("fullrw_drain_%0d", i), 32'(bus.dout), 8'h21 + i);
    end
    chk("fullrw_empty", 32'(bus.empty), 1);

    // Asynchronous reset mid-operation
    step(1'b1, 1'b0, 8'h55);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h66);
    chk("mid_pre_dout", 32'(bus.dout), 8'h55);
    #2;
    rstb_clka = 1'b0;
    #1;
    chk("mid_rst_empty", 32'(bus.empty), 1);
    chk("mid_rst_dout",  32'(bus.dout), 8'h00);
    chk("mid_rst_full",  32'(bus.full), 0);
    chk_count("mid_rst_count", 0);
    @(posedge clka);
    #1;
    rstb_clka = 1'b1;
    step(1'b0, 1'b1, 8'h00);
    chk("mid_post_dout",  32'(bus.dout), 8'h00);
    chk("mid_post_empty", 32'(bus.empty), 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
